// File: rtl/i2s_rx_pkg.sv
// Shared constants for the AHB-Lite I2S receive controller: register map,
// channel-mode encodings, sequencer states and the default read value.
package i2s_rx_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_DATA   = 8'h08;
  localparam logic [7:0] REG_IE     = 8'h0C;
  localparam logic [7:0] REG_THRESH = 8'h10;
  localparam logic [7:0] REG_CLR    = 8'h14;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_STEREO = 2'b10;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_PUSH_R = 2'd3;

  localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/i2s_sync_fifo.sv
// Single-clock circular FIFO of 32-bit words with AW+1 bit pointers so that
// full and empty are told apart by the extra wrap bit.
module i2s_sync_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [31:0] mem_q [2**AW];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok;
  logic        pop_ok;

  assign level   = wptr_q - rptr_q;
  assign full    = (level == {1'b1, {AW{1'b0}}});
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  // Flush wins over any push or pop arriving in the same cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
      if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok && !flush) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ahbl_i2s_rx_ctrl.sv
// AHB-Lite slave that follows I2S frame boundaries on ws, selects channels
// per CTRL.MODE and buffers the samples in a FIFO drained through DATA.
module ahbl_i2s_rx_ctrl
  import i2s_rx_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        ws,
  input  logic [63:0] rx_data,
  output logic        i2s_en,
  output logic        irq
);

  logic [7:0]       addr_q, addr_d;
  logic             sel_q, sel_d;
  logic             write_q, write_d;
  logic             trans_q, trans_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       ie_q, ie_d;
  logic [FIFO_AW:0] thresh_q, thresh_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic             ws_q, ws_d;
  logic [1:0]       state_q, state_d;
  logic [31:0]      hold_q, hold_d;

  logic             valid, wr, rd, frame_evt;
  logic             push_req, pop, flush;
  logic [31:0]      push_data;
  logic [31:0]      fifo_dout;
  logic [FIFO_AW:0] level;
  logic             full, empty;
  logic             unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:8], HTRANS[0], HWDATA};

  assign valid     = sel_q & trans_q;
  assign wr        = valid & write_q;
  assign rd        = valid & ~write_q;
  assign frame_evt = ~ws & ws_q;
  assign pop       = rd & (addr_q == REG_DATA) & ~empty;
  assign flush     = wr & (addr_q == REG_CTRL) & HWDATA[3];

  assign HREADYOUT = 1'b1;
  assign i2s_en    = en_q;
  assign irq       = irq_q;

  always_comb begin
    addr_d   = HREADY ? HADDR[7:0] : addr_q;
    sel_d    = HREADY ? HSEL       : sel_q;
    write_d  = HREADY ? HWRITE     : write_q;
    trans_d  = HREADY ? HTRANS[1]  : trans_q;
    ws_d     = ws;
    en_d     = en_q;
    mode_d   = mode_q;
    ie_d     = ie_q;
    thresh_d = thresh_q;
    if (wr) begin
      case (addr_q)
        REG_CTRL: begin
          en_d   = HWDATA[0];
          mode_d = HWDATA[2:1];
        end
        REG_IE:     ie_d     = HWDATA[1:0];
        REG_THRESH: thresh_d = HWDATA[FIFO_AW:0];
        default: ;
      endcase
    end
  end

  // Mode is sampled only at a frame event, so a pending right word always
  // completes even if software changes MODE in the middle of a pair.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push_req  = 1'b0;
    push_data = rx_data[63:32];
    case (state_q)
      ST_OFF:  if (en_q) state_d = ST_SYNC;
      ST_SYNC: if (frame_evt) state_d = ST_RUN;
      ST_RUN: begin
        if (frame_evt) begin
          push_req = 1'b1;
          case (mode_q)
            MODE_RIGHT:  push_data = rx_data[31:0];
            MODE_STEREO: begin
              hold_d  = rx_data[31:0];
              state_d = ST_PUSH_R;
            end
            default: ;
          endcase
        end
      end
      ST_PUSH_R: begin
        push_req  = 1'b1;
        push_data = hold_q;
        state_d   = ST_RUN;
      end
      default: state_d = ST_OFF;
    endcase
    if (!en_q) begin
      state_d  = ST_OFF;
      push_req = 1'b0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr && (addr_q == REG_CLR) && HWDATA[0]) ovf_d = 1'b0;
    if (push_req && full) ovf_d = 1'b1;
    irq_d = (ie_q[0] & (level >= thresh_q) & (thresh_q != '0)) | (ie_q[1] & ovf_q);
  end

  always_comb begin
    HRDATA = DEFAULT_RDATA;
    if (rd) begin
      case (addr_q)
        REG_CTRL:   HRDATA = {29'h0, mode_q, en_q};
        REG_STATUS: HRDATA = {16'h0, 8'(level), 5'h0, ovf_q, full, empty};
        REG_DATA:   HRDATA = empty ? DEFAULT_RDATA : fifo_dout;
        REG_IE:     HRDATA = {30'h0, ie_q};
        REG_THRESH: HRDATA = 32'(thresh_q);
        REG_CLR:    HRDATA = 32'h0;
        default:    HRDATA = DEFAULT_RDATA;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      sel_q    <= 1'b0;
      write_q  <= 1'b0;
      trans_q  <= 1'b0;
      en_q     <= 1'b0;
      mode_q   <= MODE_LEFT;
      ie_q     <= '0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      ws_q     <= 1'b1;
      state_q  <= ST_OFF;
      hold_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      write_q  <= write_d;
      trans_q  <= trans_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      ws_q     <= ws_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
    end
  end

  i2s_sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   (push_data),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule
